// File: rtl/key_onehot_scan.sv
// Four-key scanner: synchronizes and debounces raw push-buttons, then latches the
// last single pressed key as a one-hot code for a downstream 4-to-2 encoder.
module key_onehot_scan #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  output logic [3:0] x,
  output logic       en,
  output logic       key_pulse,
  output logic       multi_err
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    MULTI = 2'd2
  } state_t;

  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] stable_q;
  logic [3:0] stable_d;
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  state_t     state_q;
  state_t     state_d;
  logic [3:0] x_q;
  logic [3:0] x_d;
  logic       en_q;
  logic       en_d;
  logic       pulse_q;
  logic       pulse_d;
  logic       err_q;
  logic       err_d;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Debounce: a new level is adopted only after DEB_CYCLES consecutive mismatches.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = 8'd0;
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == DEB_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Two-flop synchronizers plus per-key debounce state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 4'b0000;
      sync2_q  <= 4'b0000;
      stable_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      sync1_q  <= key_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Key FSM: only a clean single press from IDLE updates x and strobes key_pulse.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    en_d    = en_q;
    pulse_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (stable_q == 4'b0000) begin
          state_d = IDLE;
        end else if (is_onehot(stable_q)) begin
          state_d = PRESS;
          x_d     = stable_q;
          en_d    = 1'b1;
          pulse_d = 1'b1;
        end else begin
          state_d = MULTI;
          err_d   = 1'b1;
        end
      end
      PRESS: begin
        if (stable_q == x_q) begin
          state_d = PRESS;
        end else if (stable_q == 4'b0000) begin
          state_d = IDLE;
        end else begin
          state_d = MULTI;
          err_d   = 1'b1;
        end
      end
      MULTI: begin
        if (stable_q == 4'b0000) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end else begin
          state_d = MULTI;
        end
      end
      default: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  // FSM state and its registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= 4'b0000;
      en_q    <= 1'b0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      en_q    <= en_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  assign x         = x_q;
  assign en        = en_q;
  assign key_pulse = pulse_q;
  assign multi_err = err_q;

endmodule

// File: tb/tb_key_onehot_scan.sv
// Directed bench for key_onehot_scan with DEB_CYCLES=4 (press accepted 7 edges after input change).
module tb_key_onehot_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] x;
  logic       en;
  logic       key_pulse;
  logic       multi_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  key_onehot_scan #(.DEB_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .x         (x),
    .en        (en),
    .key_pulse (key_pulse),
    .multi_err (multi_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    key_in = 4'b1111;
    #2;
    total_cnt++;
    if ({x, en, key_pulse, multi_err} !== 7'b0000000) $display("FAIL reset_async: got %b expected %b", {x, en, key_pulse, multi_err}, 7'b0000000);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if ({x, en, key_pulse, multi_err} !== 7'b0000000) $display("FAIL reset_held: got %b expected %b", {x, en, key_pulse, multi_err}, 7'b0000000);
    else pass_cnt++;
    key_in = 4'b0000;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if ({x, en, key_pulse, multi_err} !== 7'b0000000) $display("FAIL reset_release: got %b expected %b", {x, en, key_pulse, multi_err}, 7'b0000000);
    else pass_cnt++;
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    key_in = 4'b0010;
    repeat (6) begin tick(); if (key_pulse !== 1'b0) pulses++; end
    total_cnt++;
    if (pulses !== 0) $display("FAIL clean_early_pulse: got %0d expected %0d", pulses, 0);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({key_pulse, x, en} !== 6'b1_0010_1) $display("FAIL clean_accept: got %b expected %b", {key_pulse, x, en}, 6'b1_0010_1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (key_pulse !== 1'b0) $display("FAIL clean_pulse_width: got %b expected %b", key_pulse, 1'b0);
    else pass_cnt++;
    key_in = 4'b0000;
    pulses = 0;
    repeat (10) begin tick(); if (key_pulse !== 1'b0) pulses++; end
    total_cnt++;
    if ({pulses[3:0], x, en} !== 9'b0000_0010_1) $display("FAIL clean_release: got pulses=%0d x=%b en=%b expected pulses=0 x=0010 en=1", pulses, x, en);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int s = 0; s < 6; s++) begin
      key_in = (s % 2 == 0) ? 4'b0100 : 4'b0000;
      repeat (2) begin tick(); if (key_pulse !== 1'b0) pulses++; end
    end
    key_in = 4'b0100;
    repeat (6) begin tick(); if (key_pulse !== 1'b0) pulses++; end
    total_cnt++;
    if (pulses !== 0) $display("FAIL bounce_no_pulse: got %0d expected %0d", pulses, 0);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({key_pulse, x} !== 5'b1_0100) $display("FAIL bounce_accept: got %b expected %b", {key_pulse, x}, 5'b1_0100);
    else pass_cnt++;
    key_in = 4'b0000;
    repeat (10) tick();
  endtask

  task automatic test_multi();
    int pulses = 0;
    key_in = 4'b0001;
    repeat (7) tick();
    total_cnt++;
    if ({key_pulse, x} !== 5'b1_0001) $display("FAIL multi_first_key: got %b expected %b", {key_pulse, x}, 5'b1_0001);
    else pass_cnt++;
    key_in = 4'b1001;
    repeat (6) begin tick(); if (key_pulse !== 1'b0) pulses++; end
    total_cnt++;
    if (multi_err !== 1'b0) $display("FAIL multi_early: got %b expected %b", multi_err, 1'b0);
    else pass_cnt++;
    tick();
    if (key_pulse !== 1'b0) pulses++;
    total_cnt++;
    if ({multi_err, x, pulses[3:0]} !== 9'b1_0001_0000) $display("FAIL multi_set: got err=%b x=%b pulses=%0d expected err=1 x=0001 pulses=0", multi_err, x, pulses);
    else pass_cnt++;
    key_in = 4'b0000;
    repeat (6) tick();
    total_cnt++;
    if (multi_err !== 1'b1) $display("FAIL multi_hold: got %b expected %b", multi_err, 1'b1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (multi_err !== 1'b0) $display("FAIL multi_clear: got %b expected %b", multi_err, 1'b0);
    else pass_cnt++;
    key_in = 4'b1000;
    repeat (7) tick();
    total_cnt++;
    if ({key_pulse, x} !== 5'b1_1000) $display("FAIL multi_next_key: got %b expected %b", {key_pulse, x}, 5'b1_1000);
    else pass_cnt++;
    key_in = 4'b0000;
    repeat (10) tick();
  endtask

  task automatic test_simultaneous();
    int pulses = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    key_in = 4'b0011;
    repeat (6) begin tick(); if (key_pulse !== 1'b0) pulses++; end
    total_cnt++;
    if (multi_err !== 1'b0) $display("FAIL simul_early: got %b expected %b", multi_err, 1'b0);
    else pass_cnt++;
    tick();
    if (key_pulse !== 1'b0) pulses++;
    total_cnt++;
    if ({multi_err, x, en, pulses[3:0]} !== 10'b1_0000_0_0000) $display("FAIL simul_multi: got err=%b x=%b en=%b pulses=%0d expected err=1 x=0000 en=0 pulses=0", multi_err, x, en, pulses);
    else pass_cnt++;
    key_in = 4'b0000;
    repeat (10) begin tick(); if (key_pulse !== 1'b0) pulses++; end
    total_cnt++;
    if ({multi_err, pulses[3:0]} !== 5'b0_0000) $display("FAIL simul_release: got err=%b pulses=%0d expected err=0 pulses=0", multi_err, pulses);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    key_in = 4'b0100;
    repeat (7) tick();
    total_cnt++;
    if ({key_pulse, x, en} !== 6'b1_0100_1) $display("FAIL midrst_press: got %b expected %b", {key_pulse, x, en}, 6'b1_0100_1);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({x, en, key_pulse, multi_err} !== 7'b0000000) $display("FAIL midrst_truncate: got %b expected %b", {x, en, key_pulse, multi_err}, 7'b0000000);
    else pass_cnt++;
    key_in = 4'b0000;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    key_in = 4'b0010;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({x, en, key_pulse, multi_err} !== 7'b0000000) $display("FAIL midrst_debounce: got %b expected %b", {x, en, key_pulse, multi_err}, 7'b0000000);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    repeat (6) begin tick(); if (key_pulse !== 1'b0) pulses++; end
    total_cnt++;
    if (pulses !== 0) $display("FAIL midrst_early_pulse: got %0d expected %0d", pulses, 0);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({key_pulse, x, en} !== 6'b1_0010_1) $display("FAIL midrst_accept: got %b expected %b", {key_pulse, x, en}, 6'b1_0010_1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (key_pulse !== 1'b0) $display("FAIL midrst_pulse_width: got %b expected %b", key_pulse, 1'b0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
